// File: rtl/step_pulse_gen.sv
// step_pulse_gen: STEP/DIR pulse generator for one stepper driver (AUTO, RUN, RUN_N modes)
// Ports: clk, rst (async, active high); drv_en gates AUTO pulse starts;
//        period/high_cnt/n_pulses set timing and count; dir_in is the requested direction;
//        auto_en/start/start_n/stop are commands; step/dir drive the driver pins;
//        busy/done/pulse_cnt report status.
module step_pulse_gen #(
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 2000,
  parameter int DIR_SETUP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drv_en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_cnt,
  input  logic [CNT_W-1:0] n_pulses,
  input  logic             dir_in,
  input  logic             auto_en,
  input  logic             start,
  input  logic             start_n,
  input  logic             stop,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);
  typedef enum logic [2:0] {IDLE, SETUP, AUTO, RUN, RUN_N, DRAIN} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP > 0 ? DIR_SETUP - 1 : 0);
  state_t state, mode, acc_mode;
  logic [CNT_W-1:0] ph, p, h, n, p_new, h_new, ph_inc, cnt_inc;
  logic accept, wrap, cont, first_acc, first_lat;
  always_comb begin
    p_new = period == '0 ? CNT_W'(DEF_PERIOD) : period;
    h_new = (p_new == ONE || high_cnt == '0) ? ONE : (high_cnt > p_new - ONE ? p_new - ONE : high_cnt);
    acc_mode = auto_en ? AUTO : start ? RUN : RUN_N;
    accept = !stop && (auto_en || start || start_n);
    wrap = ph == p - ONE;
    ph_inc = wrap ? '0 : ph + ONE;
    // a pulse already under way that still has high cycles left after this edge
    cont = step && ph_inc != '0 && ph_inc < h;
    cnt_inc = &pulse_cnt ? pulse_cnt : pulse_cnt + ONE;
    first_acc = acc_mode != AUTO || drv_en;
    first_lat = mode != AUTO || drv_en;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mode <= IDLE;
      step <= 1'b0;
      dir <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pulse_cnt <= '0;
      ph <= '0;
      p <= '0;
      h <= '0;
      n <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          p <= p_new;
          h <= h_new;
          n <= n_pulses;
          mode <= acc_mode;
          dir <= dir_in;
          ph <= '0;
          pulse_cnt <= '0;
          if (acc_mode == RUN_N && n_pulses == '0) done <= 1'b1;
          else if (DIR_SETUP == 0) begin
            state <= acc_mode;
            busy <= 1'b1;
            step <= first_acc;
            pulse_cnt <= CNT_W'(first_acc);
          end else begin
            state <= SETUP;
            busy <= 1'b1;
          end
        end
        SETUP: if (stop || (mode == AUTO && !auto_en)) begin
          state <= IDLE;
          busy <= 1'b0;
        end else if (ph == SETUP_LAST) begin
          state <= mode;
          ph <= '0;
          step <= first_lat;
          if (first_lat) pulse_cnt <= cnt_inc;
        end else ph <= ph + ONE;
        AUTO: if (!auto_en) begin
          state <= cont ? DRAIN : IDLE;
          busy <= cont;
          step <= cont;
          ph <= ph_inc;
        end else if (wrap || (ph == '0 && !step)) begin
          // period boundary or waiting for drv_en: resample speed, start only if enabled
          ph <= '0;
          p <= p_new;
          h <= h_new;
          step <= drv_en;
          if (drv_en) pulse_cnt <= cnt_inc;
        end else begin
          ph <= ph_inc;
          step <= ph_inc < h;
        end
        RUN, RUN_N: if (state == RUN_N && wrap && pulse_cnt == n) begin
          state <= IDLE;
          busy <= 1'b0;
          step <= 1'b0;
          done <= 1'b1;
        end else if (stop) begin
          state <= cont ? DRAIN : IDLE;
          busy <= cont;
          step <= cont;
          ph <= ph_inc;
          done <= !cont && state == RUN_N;
        end else begin
          ph <= ph_inc;
          step <= ph_inc < h;
          if (wrap) pulse_cnt <= cnt_inc;
        end
        DRAIN: begin
          ph <= ph_inc;
          if (!cont) begin
            state <= IDLE;
            busy <= 1'b0;
            step <= 1'b0;
            done <= mode == RUN_N;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: randomized and directed self-checking bench for step_pulse_gen
module tb_step_pulse_gen;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b1, drv_en = 1'b0, dir_in = 1'b0;
  logic auto_en = 1'b0, start = 1'b0, start_n = 1'b0, stop = 1'b0;
  logic [W-1:0] period = '0, high_cnt = '0, n_pulses = '0;
  logic step, dir, busy, done;
  logic [W-1:0] pulse_cnt;
  int total = 0, bad = 0;
  step_pulse_gen #(.CNT_W(W), .DEF_PERIOD(2000), .DIR_SETUP(4)) dut (
    .clk(clk), .rst(rst), .drv_en(drv_en), .period(period), .high_cnt(high_cnt),
    .n_pulses(n_pulses), .dir_in(dir_in), .auto_en(auto_en), .start(start),
    .start_n(start_n), .stop(stop), .step(step), .dir(dir), .busy(busy),
    .done(done), .pulse_cnt(pulse_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic expect_out(input string tag, input int st, input int bz, input int dn, input int cnt);
    chk({tag, ".step"}, int'(step), st);
    chk({tag, ".busy"}, int'(busy), bz);
    chk({tag, ".done"}, int'(done), dn);
    chk({tag, ".pulse_cnt"}, int'(pulse_cnt), cnt);
  endtask
  // kind 0 = RUN, 1 = RUN_N; sat = mode cycle in which stop is asserted (-1: none)
  task automatic run_cmd(input int kind, input int per, input int hc, input int np,
                         input bit d, input int sat, input bit fuzz);
    int p, h, last, extra, mend, t, r;
    p = per == 0 ? 2000 : per;
    h = (p == 1 || hc == 0) ? 1 : (hc > p - 1 ? p - 1 : hc);
    @(negedge clk);
    period = W'(per);
    high_cnt = W'(hc);
    n_pulses = W'(np);
    dir_in = d;
    start = kind == 0;
    start_n = kind == 1;
    @(negedge clk);
    start = 1'b0;
    start_n = 1'b0;
    if (kind == 1 && np == 0) begin
      expect_out("zero_n", 0, 0, 1, 0);
      chk("zero_n.dir", int'(dir), int'(d));
      @(negedge clk);
      expect_out("zero_n_after", 0, 0, 0, 0);
      return;
    end
    if (sat < 0) begin
      last = np * p - 1;
      extra = 0;
    end else begin
      last = sat;
      r = (sat + 1) % p;
      extra = (r != 0 && r < h) ? h - r : 0;
    end
    mend = last + extra;
    for (int c = 1; c <= mend + 6; c++) begin
      if (c > 1) @(negedge clk);
      t = c - 5;
      if (t < 0) expect_out("setup", 0, 1, 0, 0);
      else if (t <= mend)
        expect_out(kind != 0 ? "run_n" : "run", t <= last ? int'(t % p < h) : 1, 1, 0,
                   (t <= last ? t : last) / p + 1);
      else expect_out("end", 0, 0, kind, last / p + 1);
      chk("dir", int'(dir), int'(d));
      stop = sat >= 0 && t == sat;
      period = W'($urandom);
      high_cnt = W'($urandom);
      n_pulses = W'($urandom);
      dir_in = 1'($urandom % 2);
      start = fuzz && t < mend && $urandom % 4 == 0;
      start_n = fuzz && t < mend && $urandom % 4 == 0;
    end
    stop = 1'b0;
    start = 1'b0;
    start_n = 1'b0;
  endtask
  initial begin
    int kind, per, hc, np, sat;
    @(negedge clk);
    expect_out("reset", 0, 0, 0, 0);
    chk("reset.dir", int'(dir), 0);
    rst = 1'b0;
    @(negedge clk);
    expect_out("post_reset", 0, 0, 0, 0);
    run_cmd(1, 10, 3, 5, 1'b1, -1, 1'b0);
    run_cmd(0, 0, 0, 0, 1'b0, 2000, 1'b0);
    run_cmd(1, 7, 2, 0, 1'b1, -1, 1'b0);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      expect_out("start_stop", 0, 0, 0, 0);
    end
    run_cmd(0, 6, 2, 0, 1'b0, 20, 1'b1);
    // AUTO: drv_en hold, runtime speed change, drain on auto_en release
    @(negedge clk);
    period = 8;
    high_cnt = 4;
    drv_en = 1'b1;
    auto_en = 1'b1;
    dir_in = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      expect_out("auto_setup", 0, 1, 0, 0);
    end
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      expect_out("auto_a", int'(t % 8 < 4), 1, 0, t / 8 + 1);
      if (t == 15) drv_en = 1'b0;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      expect_out("auto_hold", 0, 1, 0, 2);
      if (k == 20) drv_en = 1'b1;
    end
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      expect_out("auto_c", int'(t < 4), 1, 0, 3);
      if (t == 2) period = 16;
    end
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      expect_out("auto_d", int'(t < 4), 1, 0, 4);
      if (t == 1) drv_en = 1'b0;
      if (t == 10) drv_en = 1'b1;
    end
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      expect_out("auto_drain", 1, 1, 0, 5);
      if (t == 1) auto_en = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      expect_out("auto_idle", 0, 0, 0, 5);
      chk("auto.dir", int'(dir), 1);
    end
    for (int i = 0; i < 16; i++) begin
      kind = int'($urandom % 2);
      per = 2 + int'($urandom % 11);
      hc = int'($urandom % 15);
      np = int'($urandom % 5);
      if (kind == 0) sat = int'($urandom % (per * 4));
      else if (np > 0 && $urandom % 2 == 1) sat = int'($urandom % (np * per - 1));
      else sat = -1;
      run_cmd(kind, per, hc, np, 1'($urandom % 2), sat, 1'b1);
    end
    // asynchronous reset while a RUN_N pulse is high
    run_cmd(1, 10, 3, 0, 1'b0, -1, 1'b0);
    @(negedge clk);
    period = 10;
    high_cnt = 3;
    n_pulses = 5;
    start_n = 1'b1;
    @(negedge clk);
    start_n = 1'b0;
    for (int c = 2; c <= 5; c++) @(negedge clk);
    expect_out("pre_rst", 1, 1, 0, 1);
    #2 rst = 1'b1;
    #1 expect_out("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_out("rst_release", 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
